btn_conditioner: RTL and testbench
==================================

BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
- REQ-001 SHALL have parameter DB_CYCLES, default 1000000, meaning consecutive stable cycles required to accept a level change (10 ms at 100 MHz); legal range is 1 or more.
- REQ-002 SHALL have parameter REPEAT_DELAY, default 50000000, meaning cycles from the initial press pulse to the first auto-repeat pulse; legal range is 1 or more.
- REQ-003 SHALL have parameter REPEAT_PERIOD, default 10000000, meaning cycles between subsequent auto-repeat pulses; legal range is 1 or more.
- REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all logic is on the rising edge.
- REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
- REQ-006 SHALL have port btn_in, input, 4 bits: raw, asynchronous, bouncing button levels; 1 means pressed.
- REQ-007 SHALL have port rep_en, input, 4 bits: per-channel auto-repeat enable, synchronous to clk.
- REQ-008 SHALL have port btn_level, output, 4 bits: debounced button level.
- REQ-009 SHALL have port btn_pulse, output, 4 bits: single-cycle press and auto-repeat strobes, used as register-load enables by the downstream operand/ALU stage.

Function
- REQ-010 SHALL process the four channels independently and identically; no channel SHALL influence another.
- REQ-011 SHALL pass each btn_in bit through a 2-flop synchronizer; the second flop output is called s.
- REQ-012 SHALL keep a per-channel stability counter that clears whenever s equals btn_level, and increments on each cycle where s differs from btn_level.
- REQ-013 SHALL toggle btn_level to s on the edge that completes DB_CYCLES consecutive differing cycles, and SHALL clear the counter on that same edge.
- REQ-014 SHALL clear the stability counter on any bounce (s returning to btn_level before the count completes), with no change to btn_level.
- REQ-015 SHALL give a clean btn_in edge a latency of exactly 2+DB_CYCLES clocks to btn_level.
- REQ-016 SHALL run a per-channel FSM with states IDLE, HOLD and REPEAT, all registered.
- REQ-017 SHALL make the IDLE to HOLD transition on the btn_level rising edge; btn_pulse SHALL be 1 for exactly the cycle in which btn_level first reads 1, and the hold counter SHALL clear.
- REQ-018 SHALL, in HOLD, move to REPEAT when the hold counter reaches REPEAT_DELAY cycles after the initial pulse; btn_pulse SHALL be 1 that cycle if rep_en is 1, and the counter SHALL clear.
- REQ-019 SHALL, in REPEAT, pulse every REPEAT_PERIOD cycles when rep_en is 1 on the pulse cycle; the counter SHALL clear on each pulse.
- REQ-020 SHALL let rep_en=0 suppress repeat pulses only; FSM timing SHALL continue, so re-enabling resumes on the existing cadence.
- REQ-021 SHALL return to IDLE from any state when btn_level falls; no pulse SHALL be generated on release.
- REQ-022 SHALL never assert btn_pulse for two consecutive cycles, including when REPEAT_PERIOD=1 (in that case the pulse is every other cycle, REPEAT_PERIOD treated as minimum 2).
- REQ-023 SHALL size counters at $clog2 of the maximum of the relevant parameters plus 1 bit, with no wrap-around before the compare.

Reset
- REQ-024 SHALL, while rst=1, immediately clear btn_level, btn_pulse, the synchronizers, all counters and all FSM states (IDLE), independent of clk.
- REQ-025 SHALL, after rst falls with a button held, treat that button as a fresh press: btn_pulse at 2+DB_CYCLES clocks later.
- REQ-026 SHALL let reset mid-debounce or mid-repeat discard all partial counts.

Verification (DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
- REQ-027 SHALL cover a clean press of btn_in[0] held 8 cycles, then released: btn_level[0] rises 6 clocks later, btn_pulse[0] is high exactly 1 cycle, and btn_level[0] falls 6 clocks after release with no pulse.
- REQ-028 SHALL cover btn_in[1] toggling every 2 cycles for 20 cycles, then held high: btn_level[1] stays 0 throughout the bounce, rising 6 clocks after the final edge with exactly one pulse.
- REQ-029 SHALL cover btn_in[2] held 30 cycles past the initial pulse with rep_en[2]=1: pulses at offsets 0, 10, 13, 16, 19, 22, 25, 28 from the initial pulse.
- REQ-030 SHALL cover the same hold as REQ-029 with rep_en[2]=0: only the offset-0 pulse; raising rep_en at offset 14 yields pulses at 16, 19, ...
- REQ-031 SHALL cover rst asserted at offset 12 of a repeat sequence with the button still held: outputs go to 0 within the same cycle, and the next pulse arrives 6 clocks after rst falls.
- REQ-032 SHALL cover btn_in[3:0]=4'b1111 applied simultaneously: all four btn_pulse bits are high in the same single cycle.

Source files
------------

// File: rtl/btn_conditioner.sv
// btn_conditioner: four independent push-button channels, each with a 2-flop
// synchronizer, a stability-count debouncer and a press / auto-repeat strobe FSM.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   btn_in     in   [3:0] raw bouncing button levels (1 = pressed)
//   rep_en     in   [3:0] per-channel auto-repeat enable (synchronous)
//   btn_level  out  [3:0] debounced level (registered)
//   btn_pulse  out  [3:0] single-cycle press / repeat strobe (registered)
module btn_conditioner #(
  parameter int unsigned DB_CYCLES     = 1000000,
  parameter int unsigned REPEAT_DELAY  = 50000000,
  parameter int unsigned REPEAT_PERIOD = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_in,
  input  logic [3:0] rep_en,
  output logic [3:0] btn_level,
  output logic [3:0] btn_pulse
);

  localparam int unsigned N_CH = 4;
  // Intervals below 2 would let two strobes land on adjacent cycles.
  localparam int unsigned DLY_EFF = (REPEAT_DELAY  < 2) ? 2 : REPEAT_DELAY;
  localparam int unsigned PER_EFF = (REPEAT_PERIOD < 2) ? 2 : REPEAT_PERIOD;
  localparam int unsigned REP_MAX = (DLY_EFF > PER_EFF) ? DLY_EFF : PER_EFF;
  localparam int unsigned DB_W    = $clog2(DB_CYCLES) + 1;
  localparam int unsigned REP_W   = $clog2(REP_MAX) + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [1:0]       r_sync;
    logic [DB_W-1:0]  r_db_cnt;
    logic             r_level;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [REP_W-1:0] r_rep_cnt;
    logic [REP_W-1:0] w_rep_cnt_nxt;
    logic             r_pulse;
    logic             w_pulse_nxt;
    logic             w_s;
    logic             w_diff;
    logic             w_db_done;
    logic             w_rise;
    logic             w_fall;

    assign w_s       = r_sync[1];
    assign w_diff    = w_s ^ r_level;
    // The level flips on the edge that closes the DB_CYCLES-th differing cycle.
    assign w_db_done = w_diff && (r_db_cnt == DB_W'(DB_CYCLES - 1));
    assign w_rise    = w_db_done && w_s;
    assign w_fall    = w_db_done && !w_s;

    // Synchronizer and debouncer.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sync   <= 2'b00;
        r_db_cnt <= '0;
        r_level  <= 1'b0;
      end else begin
        r_sync <= {r_sync[0], btn_in[g]};
        if (w_db_done) begin
          r_level  <= w_s;
          r_db_cnt <= '0;
        end else if (w_diff) begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end else begin
          r_db_cnt <= '0;
        end
      end
    end

    // Strobe FSM state, interval counter and registered pulse.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state   <= ST_IDLE;
        r_rep_cnt <= '0;
        r_pulse   <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_rep_cnt <= w_rep_cnt_nxt;
        r_pulse   <= w_pulse_nxt;
      end
    end

    // Next state: decisions use the debouncer's pending edge so the press
    // strobe lands in the same cycle the level first reads 1.
    always_comb begin
      w_state_nxt   = r_state;
      w_rep_cnt_nxt = r_rep_cnt;
      w_pulse_nxt   = 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            w_state_nxt   = ST_HOLD;
            w_rep_cnt_nxt = '0;
            w_pulse_nxt   = 1'b1;
          end
        end
        ST_HOLD: begin
          if (w_fall) begin
            w_state_nxt   = ST_IDLE;
            w_rep_cnt_nxt = '0;
          end else if (r_rep_cnt == REP_W'(DLY_EFF - 1)) begin
            w_state_nxt   = ST_REPEAT;
            w_rep_cnt_nxt = '0;
            w_pulse_nxt   = rep_en[g];
          end else begin
            w_rep_cnt_nxt = r_rep_cnt + REP_W'(1);
          end
        end
        ST_REPEAT: begin
          // rep_en only masks the strobe; the cadence keeps running.
          if (w_fall) begin
            w_state_nxt   = ST_IDLE;
            w_rep_cnt_nxt = '0;
          end else if (r_rep_cnt == REP_W'(PER_EFF - 1)) begin
            w_rep_cnt_nxt = '0;
            w_pulse_nxt   = rep_en[g];
          end else begin
            w_rep_cnt_nxt = r_rep_cnt + REP_W'(1);
          end
        end
        default: begin
          w_state_nxt   = ST_IDLE;
          w_rep_cnt_nxt = '0;
        end
      endcase
    end

    assign btn_level[g] = r_level;
    assign btn_pulse[g] = r_pulse;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: scoreboard bench for btn_conditioner with
// DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
module tb_btn_conditioner;

  localparam int unsigned DB = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RP = 3;
  localparam int LAT = 2 + DB;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_in;
  logic [3:0] rep_en;
  logic [3:0] btn_level;
  logic [3:0] btn_pulse;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int q_exp[$];     // expected pulses, encoded cycle*4 + channel
  int mon_ev;
  int mon_idx[$];

  btn_conditioner #(
    .DB_CYCLES    (DB),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (btn_in),
    .rep_en   (rep_en),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every observed pulse must match a pending expected pulse.
  always @(negedge clk) begin
    for (int ch = 0; ch < 4; ch++) begin
      if (btn_pulse[ch] === 1'b1) begin
        mon_ev  = cyc * 4 + ch;
        mon_idx = q_exp.find_first_index(x) with (x == mon_ev);
        checks++;
        if (mon_idx.size() == 0) begin
          failures++;
          $display("FAIL pulse_sb: unexpected pulse ch%0d at cycle %0d (no expected pulse pending)", ch, cyc);
        end else begin
          q_exp.delete(mon_idx[0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; btn_in = 4'h0; rep_en = 4'hF;
    #1;
    checks++;
    if (btn_level !== 4'h0) begin failures++; $display("FAIL reset_level: got %b want 0000", btn_level); end
    checks++;
    if (btn_pulse !== 4'h0) begin failures++; $display("FAIL reset_pulse: got %b want 0000", btn_pulse); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (btn_level !== 4'h0) begin failures++; $display("FAIL reset_idle_level: got %b want 0000", btn_level); end
  endtask

  task automatic test_clean_press;
    int c0;
    @(negedge clk); c0 = cyc;
    btn_in[0] = 1'b1;
    q_exp.push_back((c0 + LAT) * 4 + 0);
    wait_to(c0 + LAT - 1);
    checks++;
    if (btn_level[0] !== 1'b0) begin failures++; $display("FAIL clean_rise_early: level0 got %b want 0", btn_level[0]); end
    wait_to(c0 + LAT);
    checks++;
    if (btn_level[0] !== 1'b1) begin failures++; $display("FAIL clean_rise: level0 got %b want 1", btn_level[0]); end
    wait_to(c0 + 8);
    btn_in[0] = 1'b0;
    wait_to(c0 + 8 + LAT - 1);
    checks++;
    if (btn_level[0] !== 1'b1) begin failures++; $display("FAIL clean_fall_early: level0 got %b want 1", btn_level[0]); end
    wait_to(c0 + 8 + LAT);
    checks++;
    if (btn_level[0] !== 1'b0) begin failures++; $display("FAIL clean_fall: level0 got %b want 0", btn_level[0]); end
    wait_to(c0 + 35);
    checks++;
    if (q_exp.size() != 0) begin
      failures++;
      $display("FAIL clean_missing: %0d pulses not seen, first cycle %0d ch%0d", q_exp.size(), q_exp[0] / 4, q_exp[0] % 4);
      q_exp.delete();
    end
  endtask

  task automatic test_bounce;
    int c0;
    bit bad;
    bad = 1'b0;
    @(negedge clk); c0 = cyc;
    for (int k = 0; k < 20; k++) begin
      btn_in[1] = ((k % 4) < 2);
      if (btn_level[1] !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    btn_in[1] = 1'b1;
    q_exp.push_back((c0 + 20 + LAT) * 4 + 1);
    while (cyc < c0 + 20 + LAT) begin
      if (btn_level[1] !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin failures++; $display("FAIL bounce_level: level1 rose during bounce, got 1 want 0"); end
    checks++;
    if (btn_level[1] !== 1'b1) begin failures++; $display("FAIL bounce_rise: level1 got %b want 1", btn_level[1]); end
    wait_to(c0 + 28);
    btn_in[1] = 1'b0;
    wait_to(c0 + 50);
    checks++;
    if (btn_level[1] !== 1'b0) begin failures++; $display("FAIL bounce_release: level1 got %b want 0", btn_level[1]); end
    checks++;
    if (q_exp.size() != 0) begin
      failures++;
      $display("FAIL bounce_missing: %0d pulses not seen, first cycle %0d ch%0d", q_exp.size(), q_exp[0] / 4, q_exp[0] % 4);
      q_exp.delete();
    end
  endtask

  task automatic test_repeat;
    int c0, p;
    int offs[8];
    offs = '{0, 10, 13, 16, 19, 22, 25, 28};
    rep_en[2] = 1'b1;
    @(negedge clk); c0 = cyc; p = c0 + LAT;
    btn_in[2] = 1'b1;
    foreach (offs[i]) q_exp.push_back((p + offs[i]) * 4 + 2);
    wait_to(p + 30 - LAT);
    btn_in[2] = 1'b0;
    wait_to(p + 29);
    checks++;
    if (btn_level[2] !== 1'b1) begin failures++; $display("FAIL repeat_hold_level: level2 got %b want 1", btn_level[2]); end
    wait_to(p + 30);
    checks++;
    if (btn_level[2] !== 1'b0) begin failures++; $display("FAIL repeat_release_level: level2 got %b want 0", btn_level[2]); end
    wait_to(p + 45);
    checks++;
    if (q_exp.size() != 0) begin
      failures++;
      $display("FAIL repeat_missing: %0d pulses not seen, first cycle %0d ch%0d", q_exp.size(), q_exp[0] / 4, q_exp[0] % 4);
      q_exp.delete();
    end
  endtask

  task automatic test_rep_disable;
    int c0, p;
    int offs[6];
    offs = '{0, 16, 19, 22, 25, 28};
    rep_en[2] = 1'b0;
    @(negedge clk); c0 = cyc; p = c0 + LAT;
    btn_in[2] = 1'b1;
    foreach (offs[i]) q_exp.push_back((p + offs[i]) * 4 + 2);
    wait_to(p + 14);
    rep_en[2] = 1'b1;
    wait_to(p + 30 - LAT);
    btn_in[2] = 1'b0;
    wait_to(p + 45);
    checks++;
    if (q_exp.size() != 0) begin
      failures++;
      $display("FAIL rep_disable_missing: %0d pulses not seen, first cycle %0d ch%0d", q_exp.size(), q_exp[0] / 4, q_exp[0] % 4);
      q_exp.delete();
    end
  endtask

  task automatic test_reset_mid_repeat;
    int c0, p, r;
    rep_en[2] = 1'b1;
    @(negedge clk); c0 = cyc; p = c0 + LAT;
    btn_in[2] = 1'b1;
    q_exp.push_back(p * 4 + 2);
    q_exp.push_back((p + 10) * 4 + 2);
    wait_to(p + 12);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (btn_level !== 4'h0) begin failures++; $display("FAIL midrst_level: got %b want 0000", btn_level); end
    checks++;
    if (btn_pulse !== 4'h0) begin failures++; $display("FAIL midrst_pulse: got %b want 0000", btn_pulse); end
    @(negedge clk);
    @(negedge clk);
    r = cyc;
    rst = 1'b0;
    q_exp.push_back((r + LAT) * 4 + 2);
    wait_to(r + LAT - 1);
    checks++;
    if (btn_level[2] !== 1'b0) begin failures++; $display("FAIL midrst_relatch_early: level2 got %b want 0", btn_level[2]); end
    wait_to(r + LAT);
    checks++;
    if (btn_level[2] !== 1'b1) begin failures++; $display("FAIL midrst_relatch: level2 got %b want 1", btn_level[2]); end
    wait_to(r + 8);
    btn_in[2] = 1'b0;
    wait_to(r + 30);
    checks++;
    if (q_exp.size() != 0) begin
      failures++;
      $display("FAIL midrst_missing: %0d pulses not seen, first cycle %0d ch%0d", q_exp.size(), q_exp[0] / 4, q_exp[0] % 4);
      q_exp.delete();
    end
  endtask

  task automatic test_back_to_back;
    int c0;
    rep_en = 4'h0;
    @(negedge clk); c0 = cyc;
    btn_in = 4'hF;
    for (int ch = 0; ch < 4; ch++) q_exp.push_back((c0 + LAT) * 4 + ch);
    wait_to(c0 + LAT - 1);
    checks++;
    if (btn_pulse !== 4'h0) begin failures++; $display("FAIL all_pulse_early: got %b want 0000", btn_pulse); end
    wait_to(c0 + LAT);
    checks++;
    if (btn_pulse !== 4'hF) begin failures++; $display("FAIL all_pulse: got %b want 1111", btn_pulse); end
    wait_to(c0 + LAT + 1);
    checks++;
    if (btn_pulse !== 4'h0) begin failures++; $display("FAIL all_pulse_width: got %b want 0000", btn_pulse); end
    wait_to(c0 + 8);
    btn_in = 4'h0;
    wait_to(c0 + 30);
    checks++;
    if (btn_level !== 4'h0) begin failures++; $display("FAIL all_release: got %b want 0000", btn_level); end
    checks++;
    if (q_exp.size() != 0) begin
      failures++;
      $display("FAIL all_missing: %0d pulses not seen, first cycle %0d ch%0d", q_exp.size(), q_exp[0] / 4, q_exp[0] % 4);
      q_exp.delete();
    end
    rep_en = 4'hF;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_repeat();
    test_rep_disable();
    test_reset_mid_repeat();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
